// File: rtl/spi_read_shift_reg.sv
// spi_read_shift_reg: oversampled mode-0 MSB-first SPI MISO deserialiser; spi_clk_i/spi_cs_n_i/spi_miso_i in, data_o/valid_o/ready_i word handshake, busy_o partial-word flag, sticky overrun_o cleared by clr_overrun_i
module spi_read_shift_reg #(
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_clk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_miso_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              overrun_o,
  input  logic              clr_overrun_i
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_r, state_n;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, miso_q;
  logic sclk_prev, sclk_rise, cs_act, miso_sync, shift_en, done;
  logic [DATA_W-1:0] shift_r, word;
  logic [CW-1:0] count_r;
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev;
  assign cs_act = ~cs_q[SYNC_STAGES-1];
  assign miso_sync = miso_q[SYNC_STAGES-1];
  assign shift_en = state_r == SHIFT && sclk_rise;
  assign done = shift_en && count_r == CW'(DATA_W - 1);
  assign word = {shift_r[DATA_W-2:0], miso_sync};
  assign busy_o = count_r != '0;
  always_comb state_n = cs_act ? SHIFT : IDLE;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sclk_q    <= '0;
      cs_q      <= '1;
      miso_q    <= '0;
      sclk_prev <= 1'b0;
      state_r   <= IDLE;
      shift_r   <= '0;
      count_r   <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_q      <= {cs_q[SYNC_STAGES-2:0], spi_cs_n_i};
      miso_q    <= {miso_q[SYNC_STAGES-2:0], spi_miso_i};
      sclk_prev <= sclk_q[SYNC_STAGES-1];
      state_r   <= state_n;
      if (shift_en) shift_r <= word;
      count_r   <= (!cs_act || done) ? '0 : count_r + CW'(shift_en);
      if (done && (!valid_o || ready_i)) data_o <= word;
      valid_o   <= done || (valid_o && !ready_i);
      overrun_o <= (done && valid_o && !ready_i) || (overrun_o && !clr_overrun_i);
    end
endmodule

// File: tb/tb_spi_read_shift_reg.sv
// tb_spi_read_shift_reg: directed and randomized SPI frames checked every cycle against a queue-based behavioural model
module tb_spi_read_shift_reg;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 0, rst_i = 1, spi_clk_i = 0, spi_cs_n_i = 1, spi_miso_i = 0, ready_i = 0, clr_overrun_i = 0;
  logic [W-1:0] data_o;
  logic valid_o, busy_o, overrun_o;
  int total = 0, bad = 0, cyc = 0, last_rise = 0, vrise_cyc = 0, vcycles = 0, drops = 0;
  bit rnd_on = 0, m_init = 0, vprev = 0;
  logic [W-1:0] got[$];
  logic qs[$], qc[$], qm[$], bits[$];
  logic m_sel, m_valid, m_busy, m_ovr;
  logic [W-1:0] m_data;

  spi_read_shift_reg #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst_i), .spi_clk_i(spi_clk_i), .spi_cs_n_i(spi_cs_n_i),
    .spi_miso_i(spi_miso_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .overrun_o(overrun_o), .clr_overrun_i(clr_overrun_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rnd_on) begin
        ready_i = 1'($urandom_range(0, 1));
        clr_overrun_i = ($urandom % 8) == 0;
      end
    end
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nb, input int hp);
    for (int i = 0; i < nb; i++) begin
      spi_miso_i = w[W-1-i];
      tick(hp);
      spi_clk_i = 1;
      last_rise = cyc;
      tick(hp);
      spi_clk_i = 0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n_i = 0;
    tick(2);
  endtask

  task automatic cs_high();
    tick(2);
    spi_cs_n_i = 1;
    tick(4);
  endtask

  initial begin
    logic rise, act, mb, done;
    logic [W-1:0] w;
    forever begin
      @(negedge clk);
      if (m_init) begin
        total++;
        if ({data_o, valid_o, busy_o, overrun_o} !== {m_data, m_valid, m_busy, m_ovr}) begin
          bad++;
          $display("FAIL cycle_cmp @%0d: dut data=%h v=%b b=%b o=%b, expected data=%h v=%b b=%b o=%b",
                   cyc, data_o, valid_o, busy_o, overrun_o, m_data, m_valid, m_busy, m_ovr);
        end
      end
      if (rst_i) begin
        qs.delete(); qc.delete(); qm.delete(); bits.delete();
        for (int i = 0; i <= S; i++) begin
          qs.push_back(1'b0); qc.push_back(1'b1); qm.push_back(1'b0);
        end
        {m_sel, m_valid, m_busy, m_ovr, m_data} = '0;
        m_init = 1;
      end else if (m_init) begin
        rise = qs[S-1] && !qs[S];
        act = !qc[S-1];
        mb = qm[S-1];
        done = 0;
        w = '0;
        if (!m_sel) m_sel = act;
        else begin
          if (rise) begin
            bits.push_back(mb);
            if (bits.size() == W) begin
              done = 1;
              for (int i = 0; i < W; i++) w = {w[W-2:0], bits[i]};
              bits.delete();
            end
          end
          if (!act) begin
            bits.delete();
            m_sel = 0;
          end
        end
        if (done && m_valid && !ready_i) m_ovr = 1;
        else if (clr_overrun_i) m_ovr = 0;
        if (done) begin
          if (!m_valid || ready_i) begin
            m_data = w;
            m_valid = 1;
          end
        end else if (m_valid && ready_i) m_valid = 0;
        m_busy = bits.size() != 0;
        qs.push_front(spi_clk_i); void'(qs.pop_back());
        qc.push_front(spi_cs_n_i); void'(qc.pop_back());
        qm.push_front(spi_miso_i); void'(qm.pop_back());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (valid_o && !vprev) vrise_cyc = cyc;
    if (!valid_o && vprev) drops++;
    if (valid_o) vcycles++;
    if (valid_o && ready_i) got.push_back(data_o);
    vprev = valid_o;
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      spi_clk_i = ~spi_clk_i;
      tick(1);
    end
    rst_i = 0;
    spi_clk_i = 0;
    chk("t1_data", data_o, 0);
    chk("t1_valid", valid_o, 0);
    chk("t1_busy", busy_o, 0);
    chk("t1_ovr", overrun_o, 0);
    tick(6);
    chk("t1_no_valid", valid_o, 0);

    ready_i = 1; got.delete(); vcycles = 0;
    cs_low();
    send_bits(8'hA5, 8, 2);
    cs_high();
    chk("t2_count", got.size(), 1);
    chk("t2_data", got.size() > 0 ? got[0] : 'x, 8'hA5);
    chk("t2_latency", vrise_cyc - last_rise, S + 1);
    chk("t2_vcycles", vcycles, 1);
    chk("t2_ovr", overrun_o, 0);

    ready_i = 0;
    cs_low();
    send_bits(8'h3C, 8, 2);
    send_bits(8'hC3, 8, 3);
    cs_high();
    chk("t3_data", data_o, 8'h3C);
    chk("t3_valid", valid_o, 1);
    chk("t3_ovr", overrun_o, 1);
    chk("t3_model_data", m_data, 8'h3C);
    clr_overrun_i = 1; tick(1); clr_overrun_i = 0; tick(1);
    chk("t3_clr", overrun_o, 0);
    ready_i = 1; tick(1); ready_i = 0; tick(1);
    chk("t3_consumed", valid_o, 0);

    cs_low();
    send_bits(8'h7E, 8, 2);
    tick(3);
    drops = 0;
    send_bits(8'h81, 7, 2);
    spi_miso_i = 1;
    tick(2);
    spi_clk_i = 1;
    tick(S);
    ready_i = 1;
    tick(1);
    ready_i = 0;
    spi_clk_i = 0;
    cs_high();
    chk("t4_data", data_o, 8'h81);
    chk("t4_valid", valid_o, 1);
    chk("t4_drops", drops, 0);
    chk("t4_ovr", overrun_o, 0);
    ready_i = 1; tick(1);

    got.delete();
    cs_low();
    send_bits(8'hFF, 5, 2);
    tick(2);
    chk("t5_busy", busy_o, 1);
    cs_high();
    tick(1);
    chk("t5_idle", busy_o, 0);
    cs_low();
    send_bits(8'h12, 8, 2);
    cs_high();
    chk("t5_count", got.size(), 1);
    chk("t5_data", got.size() > 0 ? got[0] : 'x, 8'h12);

    got.delete();
    cs_low();
    send_bits(8'hF0, 4, 2);
    rst_i = 1; tick(2); rst_i = 0;
    chk("t6_busy", busy_o, 0);
    tick(3);
    send_bits(8'h5A, 8, 2);
    cs_high();
    chk("t6_count", got.size(), 1);
    chk("t6_data", got.size() > 0 ? got[0] : 'x, 8'h5A);

    got.delete();
    cs_low();
    send_bits(8'h96, 7, 2);
    spi_miso_i = 0;
    tick(2);
    spi_clk_i = 1;
    spi_cs_n_i = 1;
    tick(2);
    spi_clk_i = 0;
    tick(5);
    chk("t7_count", got.size(), 1);
    chk("t7_data", got.size() > 0 ? got[0] : 'x, 8'h96);
    chk("t7_busy", busy_o, 0);

    rnd_on = 1;
    for (int f = 0; f < 40; f++) begin
      int hp, nw;
      hp = $urandom_range(2, 4);
      nw = $urandom_range(1, 3);
      cs_low();
      for (int k = 0; k < nw; k++)
        send_bits(W'($urandom), ($urandom % 6 == 0) ? $urandom_range(1, 7) : 8, hp);
      cs_high();
      if (f == 20) begin
        rst_i = 1; tick(1); rst_i = 0;
      end
    end
    rnd_on = 0;
    ready_i = 1;
    clr_overrun_i = 0;
    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
